// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, default latencies and FSM state type for the
// multi-cycle multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;
  localparam logic [2:0] MDU_MADD  = 3'b111;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the MDU.
interface mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output SrcA, SrcB, MDUOp, Start, input Busy, HI, LO);
  modport slave  (input SrcA, SrcB, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result for a latched MDU op. Returns the next
// {HI,LO}; a zero divisor returns the current {HI,LO} unchanged.
// madd support is compiled in when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] res
);

  logic [63:0] prod_s, prod_u;
  logic        sgn, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_u, r_u;

  // One unsigned divider serves both div and divu: signed divide works on
  // magnitudes and fixes signs afterwards (quotient toward zero, remainder
  // follows the dividend). 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    sgn    = (op == MDU_DIV);
    neg_a  = sgn & a[31];
    neg_b  = sgn & b[31];
    mag_a  = neg_a ? -a : a;
    mag_b  = neg_b ? -b : b;
    q_u    = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    r_u    = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    res    = hilo;
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b != 32'd0)
          res = {(neg_a ? -r_u : r_u), ((neg_a ^ neg_b) ? -q_u : q_u)};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = hilo + prod_s;
`endif
      default:   res = hilo;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO.
// IDLE/RUN FSM with a 4-bit down-counter; results land in HI/LO on the edge
// the counter is seen at zero. Define MDU_MADD_EN to enable op 111 (madd).
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi, lo;
  logic [63:0] res;
  logic        long_op, is_div, launch, wr_res, wr_hi, wr_lo;

  mdu_calc u_calc (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hilo ({hi, lo}),
    .res  (res)
  );

  // Decode which requested ops occupy the unit and which latency they use.
  always_comb begin
    long_op = 1'b0;
    is_div  = (bus.MDUOp == MDU_DIV) || (bus.MDUOp == MDU_DIVU);
    case (bus.MDUOp)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; Start is only looked at in IDLE, so mthi/mtlo in RUN drop.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    launch   = 1'b0;
    wr_res   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          if (long_op) begin
            launch   = 1'b1;
            state_nx = RUN;
            cnt_nx   = is_div ? DIV_LD : MUL_LD;
          end else if (bus.MDUOp == MDU_MTHI) begin
            wr_hi = 1'b1;
          end else if (bus.MDUOp == MDU_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          wr_res   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latches: captured once at launch so later input changes are moot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= MDU_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (launch) begin
      op_q <= bus.MDUOp;
      a_q  <= bus.SrcA;
      b_q  <= bus.SrcB;
    end
  end

  // HI/LO: written only by mthi/mtlo in IDLE or by the final RUN edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (wr_res) begin
      hi <= res[63:32];
      lo <= res[31:0];
    end else begin
      if (wr_hi) hi <= bus.SrcA;
      if (wr_lo) lo <= bus.SrcA;
    end
  end

  assign bus.Busy = (state == RUN);
  assign bus.HI   = hi;
  assign bus.LO   = lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed literal checks plus randomized traffic, with a
// cycle-level reference model (64-bit arithmetic) compared every cycle.
module tb_mdu;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  mdu_if bus();

  mdu #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {valid, {HI,LO}} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [64:0] r;
    r = {1'b0, hl};
    case (op)
      3'd1: r = {1'b1, 64'(sa * sb)};
      3'd2: r = {1'b1, 64'(ua * ub)};
      3'd3: if (b != 0) r = {1'b1, 32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b != 0) r = {1'b1, 32'(ua % ub), 32'(ua / ub)};
      3'd7: r = {1'b1, hl + 64'(sa * sb)};
      default: r = {1'b0, hl};
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return MULC;
      3'd3, 3'd4: return DIVC;
`ifdef MDU_MADD_EN
      3'd7: return MULC;
`endif
      default: return 0;
    endcase
  endfunction

  // Model: remaining busy cycles plus the pending result computed at Start.
  int          rem;
  logic        pv;
  logic [63:0] pend;
  logic [31:0] mh, ml;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= 0; pv <= 1'b0; pend <= '0; mh <= '0; ml <= '0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1 && pv) begin
        mh <= pend[63:32];
        ml <= pend[31:0];
      end
    end else if (bus.Start) begin
      if (bus.MDUOp == 3'd5) mh <= bus.SrcA;
      else if (bus.MDUOp == 3'd6) ml <= bus.SrcA;
      else if (lat_of(bus.MDUOp) > 0) begin
        logic [64:0] r;
        r = ref_op(bus.MDUOp, bus.SrcA, bus.SrcB, {mh, ml});
        rem  <= lat_of(bus.MDUOp);
        pv   <= r[64];
        pend <= r[63:0];
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_busy", {31'b0, bus.Busy}, {31'b0, (rem != 0)});
      chk("cyc_hi", bus.HI, mh);
      chk("cyc_lo", bus.LO, ml);
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd0; bus.SrcA = $urandom; bus.SrcB = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.Start = 1'b0; bus.MDUOp = 3'd0; bus.SrcA = '0; bus.SrcB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;

    // mult -3 * 5
    do_op(3'd1, 32'hFFFFFFFD, 32'd5);
    wait_idle(n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFF1);

    // multu 0xFFFFFFFF * 2, HI/LO frozen during RUN
    do_op(3'd2, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
    chk("multu_hold_hi", bus.HI, 32'hFFFFFFFF);
    chk("multu_hold_lo", bus.LO, 32'hFFFFFFF1);
    wait_idle(n);
    chk("multu_hi", bus.HI, 32'h00000001);
    chk("multu_lo", bus.LO, 32'hFFFFFFFE);

    // div -7 / 2
    do_op(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);

    // overflow case 0x80000000 / -1
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf_lo", bus.LO, 32'h80000000);
    chk("divovf_hi", bus.HI, 32'h0);

    // divu by zero keeps preset HI/LO
    do_op(3'd5, 32'h11, 32'h0);
    chk("mthi", bus.HI, 32'h11);
    do_op(3'd6, 32'h22, 32'h0);
    chk("mtlo", bus.LO, 32'h22);
    do_op(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    chk("divz_busy_cycles", 32'(n), 32'd10);
    chk("divz_hi", bus.HI, 32'h11);
    chk("divz_lo", bus.LO, 32'h22);

    // mtlo during a mult is dropped
    do_op(3'd1, 32'd3, 32'd4);
    bus.Start = 1'b1; bus.MDUOp = 3'd6; bus.SrcA = 32'h55;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = 3'd0;
    wait_idle(n);
    chk("mtlo_ign_hi", bus.HI, 32'h0);
    chk("mtlo_ign_lo", bus.LO, 32'd12);

    // reset in cycle 3 of a div, then a normal mult
    do_op(3'd3, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rstmid_hi", bus.HI, 32'd0);
    chk("rstmid_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd1, 32'd6, 32'd7);
    wait_idle(n);
    chk("post_rst_busy_cycles", 32'(n), 32'd5);
    chk("post_rst_lo", bus.LO, 32'd42);
    chk("post_rst_hi", bus.HI, 32'd0);

    // madd 1 * 1 onto HI=0, LO=0xFFFFFFFF
    do_op(3'd5, 32'h0, 32'h0);
    do_op(3'd6, 32'hFFFFFFFF, 32'h0);
    do_op(3'd7, 32'd1, 32'd1);
    wait_idle(n);
`ifdef MDU_MADD_EN
    chk("madd_busy_cycles", 32'(n), 32'd5);
    chk("madd_hi", bus.HI, 32'h1);
    chk("madd_lo", bus.LO, 32'h0);
`else
    chk("madd_off_busy_cycles", 32'(n), 32'd0);
    chk("madd_off_hi", bus.HI, 32'h0);
    chk("madd_off_lo", bus.LO, 32'hFFFFFFFF);
`endif

    // randomized traffic, including Start while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.Start = ($urandom_range(0, 2) == 0);
      bus.MDUOp = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: bus.SrcA = 32'h80000000;
        1: bus.SrcA = 32'($urandom_range(0, 20));
        default: bus.SrcA = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: bus.SrcB = 32'd0;
        1: bus.SrcB = 32'hFFFFFFFF;
        2: bus.SrcB = 32'($urandom_range(1, 9));
        default: bus.SrcB = $urandom;
      endcase
    end
    @(negedge clk);
    bus.Start = 1'b0;
    wait_idle(n);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core, the sequential counterpart of the single-cycle EX-stage ALU. It accepts operands and an operation code alongside the ALU, runs multiplies and divides over a fixed number of cycles with a `Busy` handshake, and holds results in architectural `HI`/`LO` registers. The hazard unit stalls on `Start | Busy` for any later MDU instruction. Register-file writeback reads `HI` and `LO` directly.

## Interface
- `MUL_CYCLES`, default 5: `Busy` cycles for `mult`/`multu` (and `madd`).
- `DIV_CYCLES`, default 10: `Busy` cycles for `div`/`divu`.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `SrcA` input 32: first operand (rs); value for `mthi`/`mtlo`.
- `SrcB` input 32: second operand (rt).
- `MDUOp` input 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 madd (see Configuration).
- `Start` input 1: one-cycle request; `MDUOp`, `SrcA` and `SrcB` are sampled in the same cycle.
- `Busy` output 1: high while an operation is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- State machine: IDLE and RUN. A 4-bit down-counter tracks progress.
- IDLE:
  - `Start` with a mult, multu, div, divu or madd op: latch the operands and op, load the counter with the latency minus one, go to RUN.
  - `Start` with mthi or mtlo: write `SrcA` to `HI` or `LO` at that edge. `Busy` stays low.
  - `Start` with op 000: no effect.
- RUN: the counter decrements each cycle. When it reaches 0, the edge writes the result to `HI`/`LO` and the machine returns to IDLE.
- `Start` in RUN is ignored entirely; this includes mthi and mtlo.
- mult: 64-bit signed product; `HI` gets bits 63:32, `LO` gets bits 31:0.
- multu: 64-bit unsigned product; same `HI`/`LO` split as mult.
- div: signed divide; `LO` = quotient (truncated toward zero), `HI` = remainder (takes the sign of the dividend).
- 0x80000000 / 0xFFFFFFFF: `LO` = 0x80000000, `HI` = 0.
- divu: unsigned divide; `LO` = quotient, `HI` = remainder.
- Divisor 0, div or divu: full `DIV_CYCLES` busy period, then `HI`/`LO` left unchanged.
- `HI`/`LO` keep their old values for the whole RUN period; there is no partial update.
- The result is computed from the latched operands, so input changes during RUN have no effect.

## Timing
- Reset values: `Busy` = 0, `HI` = 0, `LO` = 0; state = IDLE; counter = 0.
- `Start` at edge N (mult): `Busy` is high from after edge N through edge N+5. `HI`/`LO` update at edge N+5, and `Busy` falls at that same edge.
- Div: identical, with 10 replacing 5.
- mthi/mtlo: the register updates at edge N; zero busy cycles.
- A new `Start` is accepted in the cycle right after `Busy` falls.
- `reset` asserted mid-RUN: the operation is abandoned, `HI`/`LO` are zeroed, and `Busy` goes low asynchronously.

## Configuration
- `MDU_MADD_EN` defined:
  - op 111 (madd) is legal: signed 64-bit accumulate, {`HI`,`LO`} ← {`HI`,`LO`} + `SrcA`×`SrcB` (signed).
  - The sum wraps mod 2^64.
  - Latency is `MUL_CYCLES`.
  - The accumulate base is the `HI`/`LO` value at the Start edge.
- `MDU_MADD_EN` undefined: op 111 is treated as op 000 (no effect, no `Busy`).

## Structure
- Shared package holds:
  - `MDUOp` encoding constants `MDU_NONE` … `MDU_MADD`.
  - Default latency constants.
  - State enum {IDLE, RUN}.
- Sub-module `mdu_calc` (combinational) is natural: it takes the latched operands and op plus the current {`HI`,`LO`}, and returns the 64-bit next {`HI`,`LO`}. The divide-by-zero hold case lives there.
- The top level owns the FSM, counter, operand latches and the `HI`/`LO` registers.

## Test plan
- mult, `SrcA`=0xFFFFFFFD (-3), `SrcB`=5 → `Busy` high exactly 5 cycles; then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFF1.
- multu, 0xFFFFFFFF × 2 → `HI`=0x00000001, `LO`=0xFFFFFFFE; `HI`/`LO` unchanged while `Busy`.
- div, -7 / 2 → after 10 busy cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
- divu, 7 / 0 with `HI`=0x11, `LO`=0x22 preset via mthi/mtlo → 10 busy cycles, then `HI`=0x11, `LO`=0x22.
- Start mtlo 0x55 in the middle of a mult → ignored, `LO`=mult result.
- Separately: `reset` on cycle 3 of a div → `Busy`=0, `HI`=`LO`=0; next mult completes normally.
- `MDU_MADD_EN` defined: `HI`=0, `LO`=0xFFFFFFFF, madd 1×1 → `HI`=1, `LO`=0.
- `MDU_MADD_EN` undefined: the same op leaves `HI`/`LO` unchanged and `Busy`=0.
